// File: rtl/ps2_key_pkg.sv
// Shared key-message definitions: release code, key count default,
// encoder FSM states and the one-hot key code helper.
package ps2_key_pkg;

  localparam logic [7:0] RELEASE_CODE = 8'h80;
  localparam int         NUM_KEYS_DEF = 7;

  typedef enum logic [2:0] {
    IDLE,
    SEND_PRESS,
    SEND_BREAK,
    GAP_REL,
    SEND_REL_KEY,
    GAP
  } enc_state_t;

  function automatic logic [7:0] key_code(
    input logic [2:0] idx
  );
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// Key-message link: 8-bit code, valid strobe, ready.
// master drives code/valid and samples ready; slave is the receiver.
interface key_event_encoder_if;

  logic [7:0] key_encoding;
  logic       new_ps2_msg;
  logic       msg_ready;

  modport master (
    output key_encoding,
    output new_ps2_msg,
    input  msg_ready
  );

  modport slave (
    input  key_encoding,
    input  new_ps2_msg,
    output msg_ready
  );

endinterface

// File: rtl/key_input_sync.sv
// WIDTH-bit x STAGES-deep synchronizer for asynchronous button levels.
// Ports: clk, reset_n (sync, active low), raw in, synced out.
module key_input_sync #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain[0] <= raw;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign synced = chain[STAGES-1];

endmodule

// File: rtl/key_event_encoder.sv
// Turns button levels into press / release(0x80 + key) messages.
// Ports: polling_clk, reset_n, is_key_pressed, link (master), busy, reported_keys.
module key_event_encoder
  import ps2_key_pkg::*;
#(
  parameter int NUM_KEYS    = NUM_KEYS_DEF,
  parameter int MSG_GAP     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                polling_clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] is_key_pressed,
  key_event_encoder_if.master link,
  output logic                busy,
  output logic [NUM_KEYS-1:0] reported_keys
);

  localparam int GW = (MSG_GAP > 1) ? $clog2(MSG_GAP) : 1;

  logic [NUM_KEYS-1:0] sync_keys;
  logic [NUM_KEYS-1:0] press_pend;
  logic [NUM_KEYS-1:0] rel_pend;
  logic [NUM_KEYS-1:0] sel_mask;
  logic [2:0]          press_idx;
  logic [2:0]          rel_idx;
  logic [2:0]          sel_idx;
  logic [GW-1:0]       gap_cnt;
  logic                gap_last;
  logic [7:0]          enc_q;
  logic                vld_q;
  enc_state_t          state;

  key_input_sync #(
    .WIDTH  (NUM_KEYS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (polling_clk),
    .reset_n (reset_n),
    .raw     (is_key_pressed),
    .synced  (sync_keys)
  );

  assign press_pend = sync_keys & ~reported_keys;
  assign rel_pend   = ~sync_keys & reported_keys;

  // descending scan so the lowest pending index is left standing
  always_comb begin
    press_idx = '0;
    rel_idx   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press_pend[i]) press_idx = 3'(i);
      if (rel_pend[i])   rel_idx   = 3'(i);
    end
  end

  assign sel_mask = NUM_KEYS'(key_code(sel_idx));
  assign gap_last = (gap_cnt == GW'(MSG_GAP - 1));

  always_ff @(posedge polling_clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      sel_idx       <= '0;
      gap_cnt       <= '0;
      reported_keys <= '0;
      vld_q         <= 1'b0;
      enc_q         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|rel_pend) begin
            state   <= SEND_BREAK;
            sel_idx <= rel_idx;
            vld_q   <= 1'b1;
            enc_q   <= RELEASE_CODE;
          end else if (|press_pend) begin
            state   <= SEND_PRESS;
            sel_idx <= press_idx;
            vld_q   <= 1'b1;
            enc_q   <= key_code(press_idx);
          end
        end
        SEND_PRESS: begin
          if (link.msg_ready) begin
            reported_keys <= reported_keys | sel_mask;
            vld_q         <= 1'b0;
            enc_q         <= '0;
            gap_cnt       <= '0;
            state         <= GAP;
          end
        end
        SEND_BREAK: begin
          if (link.msg_ready) begin
            vld_q   <= 1'b0;
            enc_q   <= '0;
            gap_cnt <= '0;
            state   <= GAP_REL;
          end
        end
        // sel_idx is frozen here: the key byte must match the break
        GAP_REL: begin
          if (gap_last) begin
            state <= SEND_REL_KEY;
            vld_q <= 1'b1;
            enc_q <= key_code(sel_idx);
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        SEND_REL_KEY: begin
          if (link.msg_ready) begin
            reported_keys <= reported_keys & ~sel_mask;
            vld_q         <= 1'b0;
            enc_q         <= '0;
            gap_cnt       <= '0;
            state         <= GAP;
          end
        end
        GAP: begin
          if (gap_last) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign link.new_ps2_msg  = vld_q;
  assign link.key_encoding = enc_q;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder: reset, press/release latency,
// back-pressure, arbitration order and reset during a release.
module tb_key_event_encoder;

  logic       clk;
  logic       reset_n;
  logic [6:0] keys;
  logic       busy;
  logic [6:0] reported;

  key_event_encoder_if link ();

  key_event_encoder #(
    .NUM_KEYS    (7),
    .MSG_GAP     (4),
    .SYNC_STAGES (2)
  ) dut (
    .polling_clk    (clk),
    .reset_n        (reset_n),
    .is_key_pressed (keys),
    .link           (link.master),
    .busy           (busy),
    .reported_keys  (reported)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] xfers [$];
  int         rises [$];
  int         hi_cnt;
  logic       prev_vld;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    prev_vld = 1'b0;
    hi_cnt   = 0;
  end

  always @(negedge clk) begin
    if (link.new_ps2_msg && !prev_vld) rises.push_back(cyc);
    if (link.new_ps2_msg) hi_cnt++;
    if (link.new_ps2_msg && link.msg_ready) xfers.push_back(link.key_encoding);
    prev_vld = link.new_ps2_msg;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    xfers.delete();
    rises.delete();
    hi_cnt = 0;
  endtask

  int   n0;
  logic stable;
  logic got_it;

  initial begin
    reset_n       = 1'b0;
    keys          = '0;
    link.msg_ready = 1'b0;

    // 1: reset
    tick(3);
    check("rst_vld", 32'(link.new_ps2_msg), 0);
    check("rst_enc", 32'(link.key_encoding), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rep", 32'(reported), 0);
    reset_n = 1'b1;
    clr();
    tick(50);
    check("idle_msgs", 32'(hi_cnt), 0);
    check("idle_busy", 32'(busy), 0);

    // 2: press key 2, latency 3
    link.msg_ready = 1'b1;
    clr();
    n0   = cyc;
    keys = 7'h04;
    tick(30);
    check("p2_nrise", 32'(rises.size()), 1);
    check("p2_lat", 32'(rises[0] - n0), 3);
    check("p2_hi", 32'(hi_cnt), 1);
    check("p2_code", 32'(xfers[0]), 32'h04);
    check("p2_rep", 32'(reported), 32'h04);

    // 3: release key 2
    clr();
    keys = 7'h00;
    tick(40);
    check("r2_n", 32'(xfers.size()), 2);
    check("r2_brk", 32'(xfers[0]), 32'h80);
    check("r2_key", 32'(xfers[1]), 32'h04);
    check("r2_gap", 32'(rises[1] - rises[0]), 5);
    check("r2_rep", 32'(reported), 0);

    // 4: back-pressure on key 6
    link.msg_ready = 1'b0;
    clr();
    keys   = 7'h40;
    got_it = 1'b0;
    for (int i = 0; i < 10 && !got_it; i++) begin
      tick(1);
      got_it = link.new_ps2_msg;
    end
    check("bp_valid", 32'(got_it), 1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!(link.new_ps2_msg && link.key_encoding == 8'h40)) stable = 1'b0;
    end
    check("bp_hold", 32'(stable), 1);
    check("bp_none", 32'(xfers.size()), 0);
    link.msg_ready = 1'b1;
    tick(20);
    check("bp_one", 32'(xfers.size()), 1);
    check("bp_code", 32'(xfers[0]), 32'h40);
    check("bp_enc0", 32'(link.key_encoding), 0);
    keys = 7'h00;
    tick(40);
    check("bp_rep", 32'(reported), 0);

    // 5: arbitration order
    keys = 7'h08;
    tick(30);
    check("ar_pre", 32'(reported), 32'h08);
    clr();
    keys = 7'h21;
    tick(80);
    check("ar_n", 32'(xfers.size()), 4);
    check("ar_0", 32'(xfers[0]), 32'h80);
    check("ar_1", 32'(xfers[1]), 32'h08);
    check("ar_2", 32'(xfers[2]), 32'h01);
    check("ar_3", 32'(xfers[3]), 32'h20);
    check("ar_rep", 32'(reported), 32'h21);

    // 6: reset inside GAP_REL
    reset_n = 1'b0;
    keys    = 7'h12;
    tick(2);
    reset_n = 1'b1;
    tick(60);
    check("rr_pre", 32'(reported), 32'h12);
    clr();
    keys   = 7'h10;
    got_it = 1'b0;
    for (int i = 0; i < 20 && !got_it; i++) begin
      tick(1);
      got_it = (xfers.size() >= 1);
    end
    check("rr_brk", 32'(xfers[0]), 32'h80);
    check("rr_gap", 32'({busy, link.new_ps2_msg}), 32'b10);
    reset_n = 1'b0;
    tick(1);
    check("rr_vld", 32'(link.new_ps2_msg), 0);
    check("rr_enc", 32'(link.key_encoding), 0);
    check("rr_busy", 32'(busy), 0);
    check("rr_rep", 32'(reported), 0);
    tick(1);
    reset_n = 1'b1;
    clr();
    tick(60);
    check("rr_n", 32'(xfers.size()), 1);
    check("rr_key4", 32'(xfers[0]), 32'h10);
    check("rr_fin", 32'(reported), 32'h10);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
